// File: rtl/multicycle_cla_adder.sv
// Sequential W-bit adder built from one N-bit carry-lookahead slice.
// Processes one slice per clock, chaining the slice carry through a register.

module CarryLookAhead_Adder #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);

   logic [N-1:0] p;
   logic [N-1:0] g;
   logic [N:0]   c;

   assign p = a ^ b;
   assign g = a & b;

   // Each carry is a flat sum of generate terms gated by propagate products.
   always_comb begin
      logic prod;
      c    = '0;
      prod = 1'b0;
      c[0] = cin;
      for (int i = 0; i < N; i++) begin
         c[i+1] = g[i];
         prod   = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            c[i+1] = c[i+1] | (prod & g[j]);
            prod   = prod & p[j];
         end
         c[i+1] = c[i+1] | (prod & cin);
      end
   end

   assign s    = p ^ c[N-1:0];
   assign cout = c[N];

endmodule

module multicycle_cla_adder #(
   parameter int W = 16,
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         overflow
);

   localparam int K  = W / N;
   localparam int KW = (K > 1) ? $clog2(K) : 1;

   if (W % N != 0) begin : g_width_check
      $error("multicycle_cla_adder: W must be a multiple of N");
   end

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  sum_q;
   logic [KW-1:0] k_q;
   logic          carry_q;
   logic          cout_q;
   logic          ovf_q;
   logic          a_msb_q;
   logic          b_msb_q;
   logic [N-1:0]  slice_s;
   logic          slice_cout;
   logic          last;

   CarryLookAhead_Adder #(
      .N(N)
   ) u_cla (
      .a   (a_q[N-1:0]),
      .b   (b_q[N-1:0]),
      .cin (carry_q),
      .s   (slice_s),
      .cout(slice_cout)
   );

   assign last = (k_q == KW'(K - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = CALC;
            end
         end
         CALC: begin
            if (last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         k_q     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
      end else if (state_q == IDLE && in_valid) begin
         a_q     <= a;
         b_q     <= b;
         sum_q   <= '0;
         k_q     <= '0;
         carry_q <= cin;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         a_msb_q <= a[W-1];
         b_msb_q <= b[W-1];
      end else if (state_q == CALC) begin
         // Operands shift down so the active slice always sits at bit 0.
         a_q     <= a_q >> N;
         b_q     <= b_q >> N;
         carry_q <= slice_cout;
         k_q     <= k_q + KW'(1);
         for (int i = 0; i < K; i++) begin
            if (k_q == KW'(i)) begin
               sum_q[i*N +: N] <= slice_s;
            end
         end
         if (last) begin
            cout_q <= slice_cout;
            ovf_q  <= (a_msb_q == b_msb_q) && (slice_s[N-1] != a_msb_q);
         end
      end
   end

   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_multicycle_cla_adder.sv
// Directed bench for multicycle_cla_adder at W=16, N=4.
// Vector table plus backpressure and reset-abort sequences.

module tb_multicycle_cla_adder;

   localparam int W = 16;
   localparam int N = 4;
   localparam int K = W / N;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         overflow;

   int n_cmp = 0;
   int n_bad = 0;

   multicycle_cla_adder #(
      .W(W),
      .N(N)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Accepts one operand set, then waits for out_valid; returns edge count.
   task automatic txn(input logic [W-1:0] ai, input logic [W-1:0] bi,
                      input logic ci, output int edges);
      @(negedge clk);
      a        = ai;
      b        = bi;
      cin      = ci;
      in_valid = 1'b1;
      chk("in_ready_at_accept", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      edges    = 0;
      while (!out_valid && edges < 20) begin
         chk("in_ready_busy", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      vec_t vecs[8];
      int   edges;
      logic [W-1:0] hs;
      logic         hc;
      logic         ho;

      vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[6] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
      vecs[7] = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 8; i++) begin
         txn(vecs[i].a, vecs[i].b, vecs[i].cin, edges);
         chk($sformatf("v%0d_edges", i), 32'(edges), 32'(K));
         chk($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
         chk($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
         chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
         release_result();
      end

      // Backpressure: result held while inputs churn.
      txn(16'h7FFF, 16'h0001, 1'b0, edges);
      hs = 16'h8000;
      hc = 1'b0;
      ho = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         a        = a ^ 16'h5A5A;
         b        = b + 16'h0101;
         cin      = ~cin;
         @(posedge clk);
         #1;
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_sum", 32'(sum), 32'(hs));
         chk("bp_cout", 32'(cout), 32'(hc));
         chk("bp_ovf", 32'(overflow), 32'(ho));
      end
      in_valid = 1'b0;
      release_result();
      txn(16'h0F0F, 16'h00F1, 1'b0, edges);
      chk("bp_next_sum", 32'(sum), 32'h1000);
      chk("bp_next_edges", 32'(edges), 32'(K));
      release_result();

      // Reset mid-CALC discards the transaction.
      @(negedge clk);
      a        = 16'hAAAA;
      b        = 16'h5555;
      cin      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         chk("abort_no_stale", 32'(out_valid), 32'd0);
      end
      txn(16'h0003, 16'h0004, 1'b0, edges);
      chk("abort_next_edges", 32'(edges), 32'(K));
      chk("abort_next_sum", 32'(sum), 32'h0007);
      release_result();

      // Reset wins over a simultaneous in_valid.
      @(negedge clk);
      a        = 16'h1111;
      b        = 16'h2222;
      in_valid = 1'b1;
      rst      = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("rst_prio_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("rst_prio_still_idle", 32'(in_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
